// File: rtl/magic_cfg_master.sv
// Config-port bus initiator: turns a req/rsp handshake into a timed Z80-style
// I/O write or read of port {reg, PORT_LO}, with setup, strobe and hold phases.
module magic_cfg_master #(
   parameter int         SETUP_CLKS  = 2,
   parameter int         STROBE_CLKS = 4,
   parameter int         HOLD_CLKS   = 2,
   parameter logic [7:0] PORT_LO     = 8'hFF
) (
   input  logic        clk28,
   input  logic        rst,
   input  logic        req,
   input  logic        req_wr,
   input  logic [7:0]  req_reg,
   input  logic [7:0]  req_data,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        busy,
   output logic        map_req,
   output logic [15:0] bus_a,
   output logic [7:0]  bus_d_out,
   output logic        bus_d_oe,
   output logic        bus_ioreq,
   output logic        bus_wr,
   output logic        bus_rd,
   input  logic [7:0]  bus_d_in,
   input  logic        bus_d_in_active
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d_out;
      logic        d_oe;
      logic        ioreq;
      logic        wr;
      logic        rd;
   } bus_t;

   localparam logic [7:0] SETUP_LD  = 8'(SETUP_CLKS - 1);
   localparam logic [7:0] STROBE_LD = 8'(STROBE_CLKS - 1);
   localparam logic [7:0] HOLD_LD   = 8'(HOLD_CLKS - 1);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic       wr_l, wr_l_n;
   bus_t       bus_q, bus_n;
   logic       busy_n;
   logic [7:0] rsp_data_n;

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         wr_l      <= 1'b0;
         bus_q     <= '0;
         busy      <= 1'b0;
         map_req   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         req_ready <= 1'b1;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         wr_l      <= wr_l_n;
         bus_q     <= bus_n;
         busy      <= busy_n;
         map_req   <= busy_n;
         rsp_valid <= (state_n == DONE);
         rsp_data  <= rsp_data_n;
         req_ready <= (state_n == IDLE);
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      wr_l_n     = wr_l;
      bus_n      = bus_q;
      busy_n     = busy;
      rsp_data_n = rsp_data;
      bus_n.ioreq = 1'b0;
      bus_n.wr    = 1'b0;
      bus_n.rd    = 1'b0;
      case (state)
         IDLE: if (req) begin
            state_n     = SETUP;
            cnt_n       = SETUP_LD;
            wr_l_n      = req_wr;
            bus_n.a     = {req_reg, PORT_LO};
            bus_n.d_out = req_wr ? req_data : 8'h00;
            bus_n.d_oe  = req_wr;
            busy_n      = 1'b1;
         end
         SETUP: begin
            if (cnt == 8'd0) begin
               state_n = STROBE;
               cnt_n   = STROBE_LD;
            end else cnt_n = cnt - 8'd1;
         end
         STROBE: begin
            if (cnt == 8'd0) begin
               state_n = HOLD;
               cnt_n   = HOLD_LD;
               // an undriven data bus floats high
               rsp_data_n = wr_l ? 8'h00 : (bus_d_in_active ? bus_d_in : 8'hFF);
            end else cnt_n = cnt - 8'd1;
         end
         HOLD: begin
            if (cnt == 8'd0) begin
               state_n     = DONE;
               busy_n      = 1'b0;
               bus_n.a     = '0;
               bus_n.d_out = '0;
               bus_n.d_oe  = 1'b0;
            end else cnt_n = cnt - 8'd1;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (state_n == STROBE) begin
         bus_n.ioreq = 1'b1;
         bus_n.wr    = wr_l_n;
         bus_n.rd    = !wr_l_n;
      end
   end

   assign bus_a     = bus_q.a;
   assign bus_d_out = bus_q.d_out;
   assign bus_d_oe  = bus_q.d_oe;
   assign bus_ioreq = bus_q.ioreq;
   assign bus_wr    = bus_q.wr;
   assign bus_rd    = bus_q.rd;

endmodule

// File: tb/tb_magic_cfg_master.sv
// Bench for magic_cfg_master: default-timing instance (0) and short-timing
// instance (1); read results are scoreboarded against rsp_valid pulses.
module tb_magic_cfg_master;

   logic        clk28 = 1'b0;
   logic        rst[2];
   logic        req[2];
   logic        req_wr[2];
   logic [7:0]  req_reg[2];
   logic [7:0]  req_data[2];
   logic        req_ready[2];
   logic        rsp_valid[2];
   logic [7:0]  rsp_data[2];
   logic        busy[2];
   logic        map_req[2];
   logic [15:0] bus_a[2];
   logic [7:0]  bus_d_out[2];
   logic        bus_d_oe[2];
   logic        bus_ioreq[2];
   logic        bus_wr[2];
   logic        bus_rd[2];
   logic [7:0]  bus_d_in[2];
   logic        bus_d_in_active[2];

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   always #5 clk28 = ~clk28;

   magic_cfg_master u_dut0 (
      .clk28(clk28), .rst(rst[0]), .req(req[0]), .req_wr(req_wr[0]),
      .req_reg(req_reg[0]), .req_data(req_data[0]), .req_ready(req_ready[0]),
      .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .busy(busy[0]),
      .map_req(map_req[0]), .bus_a(bus_a[0]), .bus_d_out(bus_d_out[0]),
      .bus_d_oe(bus_d_oe[0]), .bus_ioreq(bus_ioreq[0]), .bus_wr(bus_wr[0]),
      .bus_rd(bus_rd[0]), .bus_d_in(bus_d_in[0]),
      .bus_d_in_active(bus_d_in_active[0]));

   magic_cfg_master #(.SETUP_CLKS(1), .STROBE_CLKS(2), .HOLD_CLKS(1)) u_dut1 (
      .clk28(clk28), .rst(rst[1]), .req(req[1]), .req_wr(req_wr[1]),
      .req_reg(req_reg[1]), .req_data(req_data[1]), .req_ready(req_ready[1]),
      .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .busy(busy[1]),
      .map_req(map_req[1]), .bus_a(bus_a[1]), .bus_d_out(bus_d_out[1]),
      .bus_d_oe(bus_d_oe[1]), .bus_ioreq(bus_ioreq[1]), .bus_wr(bus_wr[1]),
      .bus_rd(bus_rd[1]), .bus_d_in(bus_d_in[1]),
      .bus_d_in_active(bus_d_in_active[1]));

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
   endtask

   always @(negedge clk28) begin
      if (rsp_valid[0] === 1'b1) begin
         if (q0.size() == 0) check("dut0_unexpected_rsp", 1, 0);
         else check("dut0_rsp_data", int'(rsp_data[0]), int'(q0.pop_front()));
      end
      if (rsp_valid[1] === 1'b1) begin
         if (q1.size() == 0) check("dut1_unexpected_rsp", 1, 0);
         else check("dut1_rsp_data", int'(rsp_data[1]), int'(q1.pop_front()));
      end
   end

   task automatic wait_ready(input int d);
      int n = 0;
      while (req_ready[d] !== 1'b1 && n < 50) begin
         @(negedge clk28);
         n++;
      end
      if (n >= 50) check("ready_timeout", 0, 1);
   endtask

   // One full transaction with per-clock bus timing checks; mid-cycle the
   // request inputs are scrambled and must not reach the bus.
   task automatic run_txn(input int d, input logic wr, input logic [7:0] rg,
                          input logic [7:0] dt, input logic [7:0] di,
                          input logic act, input logic [7:0] exp);
      int s, st, h, first_io, n_io, n_oe, rsp_at, n_bad;
      s  = (d == 0) ? 2 : 1;
      st = (d == 0) ? 4 : 2;
      h  = (d == 0) ? 2 : 1;
      wait_ready(d);
      req[d] = 1'b1; req_wr[d] = wr; req_reg[d] = rg; req_data[d] = dt;
      bus_d_in[d] = di; bus_d_in_active[d] = act;
      if (d == 0) q0.push_back(exp); else q1.push_back(exp);
      @(negedge clk28);
      req[d] = 1'b0; req_wr[d] = ~wr; req_reg[d] = ~rg; req_data[d] = ~dt;
      first_io = 0; n_io = 0; n_oe = 0; rsp_at = 0; n_bad = 0;
      for (int c = 1; c <= 12; c++) begin
         if (bus_ioreq[d]) begin
            if (first_io == 0) first_io = c;
            n_io++;
            if (bus_wr[d] !== wr || bus_rd[d] !== !wr) n_bad++;
         end else if (bus_wr[d] || bus_rd[d]) n_bad++;
         if (bus_d_oe[d]) n_oe++;
         if (busy[d] && bus_a[d] !== {rg, 8'hFF}) n_bad++;
         if (busy[d] && bus_d_out[d] !== (wr ? dt : 8'h00)) n_bad++;
         if (busy[d] !== map_req[d]) n_bad++;
         if (rsp_valid[d] && rsp_at == 0) rsp_at = c;
         @(negedge clk28);
      end
      check("first_strobe_clk", first_io, s + 1);
      check("strobe_len", n_io, st);
      check("d_oe_len", n_oe, wr ? (s + st + h) : 0);
      check("rsp_clk", rsp_at, s + st + h + 1);
      check("bus_violations", n_bad, 0);
   endtask

   initial begin
      int rdy_cnt, acc2, bad;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; req_wr[d] = 1'b0; req_reg[d] = '0;
         req_data[d] = '0; bus_d_in[d] = '0; bus_d_in_active[d] = 1'b0;
      end
      repeat (3) @(negedge clk28);
      check("rst_req_ready", int'(req_ready[0]), 1);
      check("rst_rsp_valid", int'(rsp_valid[0]), 0);
      check("rst_busy", int'(busy[0]), 0);
      check("rst_map_req", int'(map_req[0]), 0);
      check("rst_bus_a", int'(bus_a[0]), 0);
      check("rst_strobes", int'({bus_ioreq[0], bus_wr[0], bus_rd[0], bus_d_oe[0]}), 0);
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk28);

      run_txn(0, 1'b1, 8'h02, 8'h03, 8'h00, 1'b0, 8'h00);
      run_txn(0, 1'b0, 8'h00, 8'h00, 8'h06, 1'b1, 8'h06);
      run_txn(0, 1'b0, 8'h05, 8'h00, 8'h3C, 1'b0, 8'hFF);

      // back-to-back with req held high
      wait_ready(0);
      req[0] = 1'b1; req_wr[0] = 1'b1; req_reg[0] = 8'h11; req_data[0] = 8'hA1;
      q0.push_back(8'h00); q0.push_back(8'h00);
      @(negedge clk28);
      req_reg[0] = 8'h22; req_data[0] = 8'hB2;
      rdy_cnt = 0; acc2 = 0; bad = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c <= 8 && (bus_a[0] !== 16'h11FF || bus_d_out[0] !== 8'hA1)) bad++;
         if (c <= 10 && req_ready[0]) rdy_cnt++;
         if (acc2 == 0 && busy[0] && bus_a[0] === 16'h22FF) begin
            acc2 = c;
            if (bus_d_out[0] !== 8'hB2) bad++;
            req[0] = 1'b0;
         end
         @(negedge clk28);
      end
      check("b2b_first_bus", bad, 0);
      check("b2b_idle_clks", rdy_cnt, 1);
      check("b2b_second_accept", acc2, 11);

      // reset during the strobe of a write
      wait_ready(0);
      req[0] = 1'b1; req_wr[0] = 1'b1; req_reg[0] = 8'h07; req_data[0] = 8'h55;
      @(negedge clk28);
      req[0] = 1'b0;
      repeat (3) @(negedge clk28);
      check("pre_rst_ioreq", int'(bus_ioreq[0]), 1);
      rst[0] = 1'b1;
      #1;
      check("rst_mid_ioreq", int'(bus_ioreq[0]), 0);
      check("rst_mid_wr", int'(bus_wr[0]), 0);
      check("rst_mid_busy", int'(busy[0]), 0);
      check("rst_mid_map_req", int'(map_req[0]), 0);
      @(negedge clk28);
      rst[0] = 1'b0;
      repeat (10) @(negedge clk28);
      check("post_rst_ready", int'(req_ready[0]), 1);
      run_txn(0, 1'b1, 8'h09, 8'h81, 8'h00, 1'b0, 8'h00);

      // short-timing instance
      run_txn(1, 1'b0, 8'h0D, 8'h00, 8'h9E, 1'b1, 8'h9E);
      run_txn(1, 1'b1, 8'h0D, 8'h44, 8'h00, 1'b0, 8'h00);

      repeat (5) @(negedge clk28);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
